// File: rtl/reg_bus_pkg.sv
// Shared definitions for the host register bus read path.
// Holds the read FSM state encoding, default bus widths, the IDs already
// assigned to existing registers, and a helper for index widths.
package reg_bus_pkg;

  localparam int unsigned RB_DW  = 16;
  localparam int unsigned RB_IDW = 16;

  // Read FSM states (legacy-compatible constants)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // IDs of the existing registers on the bus
  localparam logic [RB_IDW-1:0] ID_I2C_DATA   = RB_IDW'(1);
  localparam logic [RB_IDW-1:0] ID_I2C_STATUS = RB_IDW'(2);
  localparam logic [RB_IDW-1:0] ID_UART_DATA  = RB_IDW'(3);
  localparam logic [RB_IDW-1:0] ID_TX_COUNT   = RB_IDW'(4);
  localparam logic [RB_IDW-1:0] ID_RX_COUNT   = RB_IDW'(5);
  localparam logic [RB_IDW-1:0] ID_BUSY       = RB_IDW'(8);
  localparam logic [RB_IDW-1:0] ID_SYNC       = RB_IDW'(9);

  // Width of a slot index; at least one bit even for a single slot
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_id_decode.sv
// Combinational register-ID decoder.
// Ports: rd_id (register ID) -> hit_c (ID maps to a populated slot),
//        idx_c (slot index, valid when hit_c).
module reg_id_decode
  import reg_bus_pkg::*;
#(
  parameter int unsigned      IDW     = RB_IDW,
  parameter int unsigned      BASE_ID = 1,
  parameter int unsigned      NCH     = 9,
  parameter logic [NCH-1:0]   CH_MASK = 9'h19F,
  parameter int unsigned      IW      = idx_width(NCH)
) (
  input  logic [IDW-1:0] rd_id,
  output logic           hit_c,
  output logic [IW-1:0]  idx_c
);

  // One extra bit so IDs below BASE_ID land far outside the slot range
  logic [IDW:0] off;

  always_comb begin
    off   = {1'b0, rd_id} - (IDW+1)'(BASE_ID);
    hit_c = 1'b0;
    idx_c = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (off == (IDW+1)'(k) && CH_MASK[k]) begin
        hit_c = 1'b1;
        idx_c = IW'(k);
      end
    end
  end

endmodule

// File: rtl/reg_read_mux.sv
// Registered ID-keyed register read multiplexer with request/valid handshake.
// Ports: clk, rst_n (async active-low); rd_req/rd_id request; ch_data
// (flattened NCH x DW sources); ch_rd_ack one-hot read strobe; rd_valid,
// rd_data, rd_err response; busy while a read is in flight; drop_flag
// sticky lost-request flag cleared by drop_clr.
// Build option REG_READ_MUX_HOLD_EN: rd_data keeps the last response
// outside the response cycle instead of returning to zero.
module reg_read_mux
  import reg_bus_pkg::*;
#(
  parameter int unsigned    DW      = RB_DW,
  parameter int unsigned    IDW     = RB_IDW,
  parameter int unsigned    NCH     = 9,
  parameter int unsigned    BASE_ID = 1,
  parameter logic [NCH-1:0] CH_MASK = 9'h19F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [IDW-1:0]    rd_id,
  input  logic [NCH*DW-1:0] ch_data,
  output logic [NCH-1:0]    ch_rd_ack,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic              rd_err,
  output logic              busy,
  output logic              drop_flag,
  input  logic              drop_clr
);

  localparam int unsigned IW = idx_width(NCH);

  state_t          state_q, state_d;
  logic            dec_hit_c;
  logic [IW-1:0]   dec_idx_c;
  logic            hit_q;
  logic [IW-1:0]   idx_q;
  logic [NCH-1:0]  ack_d;
  logic [DW-1:0]   slice_c;
  logic            drop_set;

  reg_id_decode #(
    .IDW     (IDW),
    .BASE_ID (BASE_ID),
    .NCH     (NCH),
    .CH_MASK (CH_MASK),
    .IW      (IW)
  ) u_dec (
    .rd_id (rd_id),
    .hit_c (dec_hit_c),
    .idx_c (dec_idx_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, next ack strobe, selected slot and drop detection
  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    slice_c  = '0;
    drop_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d = ST_DECODE;
          for (int k = 0; k < int'(NCH); k++)
            if (dec_hit_c && dec_idx_c == IW'(k)) ack_d[k] = 1'b1;
        end
      end
      ST_DECODE: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    for (int k = 0; k < int'(NCH); k++)
      if (idx_q == IW'(k)) slice_c = ch_data[k*DW +: DW];
    drop_set = rd_req && (state_q != ST_IDLE);
  end

  // Registered outputs and the decode result carried into DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_rd_ack <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
      busy      <= 1'b0;
      drop_flag <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      ch_rd_ack <= ack_d;
      busy      <= (state_d != ST_IDLE);
      rd_valid  <= (state_d == ST_RESP);
      if (state_q == ST_IDLE && rd_req) begin
        hit_q <= dec_hit_c;
        idx_q <= dec_idx_c;
      end
      // ch_data is captured only on the closing DECODE edge
      if (state_q == ST_DECODE) begin
        rd_data <= hit_q ? slice_c : '0;
        rd_err  <= ~hit_q;
      end else if (state_q == ST_RESP) begin
        rd_err  <= 1'b0;
`ifndef REG_READ_MUX_HOLD_EN
        rd_data <= '0;
`endif
      end
      // Set has priority over clear
      drop_flag <= drop_set | (drop_flag & ~drop_clr);
    end
  end

endmodule
